// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU command issuer and its neighbours.
//   OP_*     opcode encodings understood by the ALU stage
//   ALU_LAT  register stages between alu_* and the ALU stage's out
//   OPND_W   operand width of the ALU stage
//   alu_cmd_t  one buffered command {a, b, op}
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // The valid pipe is ALU_LAT+1 long: one stage for our own issue register,
    // then ALU_LAT stages inside the ALU.
    localparam int unsigned ALU_LAT = 2;

    localparam int unsigned OPND_W = 4;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [1:0]        op;
    } alu_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: command buffer with a count register for occupancy.
//   clk, rst      clock, asynchronous active-low reset (pointers/count only)
//   push, wdata   write one entry (caller guarantees !full)
//   pop, rdata    rdata is the head entry; pop advances it (caller guarantees !empty)
//   full, empty   occupancy flags
//   count         current occupancy
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DW-1:0]                wdata,
    input  logic                         pop,
    output logic [DW-1:0]                rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Storage is deliberately not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands and issues at most one per cycle onto the
// registered ALU stage, with a res_valid strobe aligned to the ALU result.
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_ready         upstream handshake; in_ready = !full
//   in_a, in_b, in_op         command operands and opcode
//   issue_en                  downstream permit to issue this cycle
//   alu_a, alu_b, alu_op      registered command to the ALU stage
//   res_valid                 ALU out holds the result of an issued command
//   count                     FIFO occupancy
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_a,
    input  logic [W-1:0]                 in_b,
    input  logic [1:0]                   in_op,
    input  logic                         issue_en,
    output logic [W-1:0]                 alu_a,
    output logic [W-1:0]                 alu_b,
    output logic [1:0]                   alu_op,
    output logic                         res_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned DW = 2 * W + 2;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [DW-1:0] head;
    logic [ALU_LAT:0] vpipe;

    // No push-through when full and no bypass when empty: both decisions use
    // only the occupancy before the edge.
    assign push     = in_valid && !full;
    assign pop      = issue_en && !empty;
    assign in_ready = !full;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_a, in_b, in_op}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Issue register plus valid pipe; alu_* hold their value on a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            vpipe  <= '0;
        end else begin
            vpipe <= {vpipe[ALU_LAT-1:0], pop};
            if (pop) begin
                alu_a  <= head[DW-1 -: W];
                alu_b  <= head[W+1 -: W];
                alu_op <= head[1:0];
            end
        end
    end

    assign res_valid = vpipe[ALU_LAT];

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [1:0] in_op = '0;
    logic       issue_en = 1'b0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       res_valid;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of pending commands, the last command issued,
    // and the edge numbers at which issues happened.
    alu_cmd_t q[$];
    alu_cmd_t last_cmd;
    int       iss_edges[$];
    int       edge_no = 0;

    alu_cmd_issuer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .issue_en  (issue_en),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .res_valid (res_valid),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_rv();
        // A result is present exactly two edges after its issue edge.
        foreach (iss_edges[i]) if (iss_edges[i] == edge_no - 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        iss_edges.delete();
        last_cmd = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".alu_a"}, 32'(alu_a), 32'(last_cmd.a));
        chk({tag, ".alu_b"}, 32'(alu_b), 32'(last_cmd.b));
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(last_cmd.op));
        chk({tag, ".res_valid"}, 32'(res_valid), 32'(exp_rv()));
    endtask

    // One clock: drive inputs, take the edge, update the model, compare.
    task automatic step(input string tag, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic [1:0] op, input logic ie);
        logic acc;
        logic iss;
        alu_cmd_t c;
        in_valid = v; in_a = a; in_b = b; in_op = op; issue_en = ie;
        acc = rst && v && (q.size() < DEPTH);
        iss = rst && ie && (q.size() > 0);
        @(posedge clk);
        #1;
        edge_no++;
        if (!rst) begin
            model_reset();
        end else begin
            if (iss) begin
                last_cmd = q.pop_front();
                iss_edges.push_back(edge_no);
            end
            if (acc) begin
                c.a = a; c.b = b; c.op = op;
                q.push_back(c);
            end
        end
        while (iss_edges.size() > 0 && iss_edges[0] < edge_no - 2) void'(iss_edges.pop_front());
        check_all(tag);
    endtask

    initial begin
        model_reset();

        // Reset held with traffic offered.
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 4'd7, 4'd7, OP_ADD, 1'b1);
        rst = 1'b1;

        // Single command then idle: res_valid three edges after the push.
        step("single_push", 1'b1, 4'd3, 4'd5, OP_MUL, 1'b1);
        for (int i = 0; i < 4; i++) step("single_drain", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);

        // Fill with issue stalled; the 5th push is refused.
        step("fill0", 1'b1, 4'h9, 4'h6, OP_ADD, 1'b0);
        step("fill1", 1'b1, 4'hF, 4'hF, OP_MUL, 1'b0);
        step("fill2", 1'b1, 4'hA, 4'h5, OP_OR,  1'b0);
        step("fill3", 1'b1, 4'hC, 4'hA, OP_AND, 1'b0);
        step("fill4_refused", 1'b1, 4'h1, 4'h2, OP_ADD, 1'b0);
        for (int i = 0; i < 7; i++) step("drain", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);

        // Count held at 2 under simultaneous push/issue; wraps the pointers.
        step("pre0", 1'b1, 4'd1, 4'd2, OP_ADD, 1'b0);
        step("pre1", 1'b1, 4'd3, 4'd4, OP_OR,  1'b0);
        for (int i = 0; i < 8; i++)
            step("pushpop", 1'b1, 4'(i + 5), 4'(15 - i), 2'(i), 1'b1);
        for (int i = 0; i < 5; i++) step("pushpop_drain", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);

        // Bubble: issue_en 1,0,1 with a non-empty FIFO.
        for (int i = 0; i < 3; i++) step("bub_fill", 1'b1, 4'(i + 2), 4'(i + 9), OP_AND, 1'b0);
        step("bub_1", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
        step("bub_0", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b0);
        step("bub_1b", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
        for (int i = 0; i < 4; i++) step("bub_drain", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);

        // Reset mid-flight: two commands issued, then async reset.
        step("mf_push0", 1'b1, 4'd6, 4'd7, OP_MUL, 1'b0);
        step("mf_push1", 1'b1, 4'd8, 4'd9, OP_ADD, 1'b0);
        step("mf_push2", 1'b1, 4'd4, 4'd4, OP_OR,  1'b0);
        step("mf_iss0", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
        step("mf_iss1", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);
        step("mf_wait", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mf_async");
        for (int i = 0; i < 4; i++) step("mf_held", 1'b1, 4'd1, 4'd1, OP_ADD, 1'b1);
        rst = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                 2'($urandom), 1'($urandom_range(0, 99) < 60));
        for (int i = 0; i < 8; i++) step("rand_drain", 1'b0, 4'd0, 4'd0, OP_ADD, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
